ocd_watch: RTL

OCD_WATCH -- requirements
Module: ocd_watch

---
 rtl/ocd_watch_pkg.sv | 48 ++++
 rtl/ocd_trace_fifo.sv | 53 +++++
 rtl/ocd_watch.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ocd_watch_pkg.sv
// Shared types and trace-entry layout for the on-chip debug bus watcher.
package ocd_watch_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StAddr = 3'd1,
    StData = 3'd2,
    StHalt = 3'd3,
    StStop = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ModeOff   = 2'd0,
    ModeFetch = 2'd1,
    ModeWrite = 2'd2,
    ModeData  = 2'd3
  } mode_e;

  // Trace entry layout, LSB first: {wr, dc, mio, a, din}
  localparam int unsigned TrcDinLsb = 0;

  function automatic int unsigned trc_a_lsb(int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned trc_mio_bit(int unsigned addr_w, int unsigned data_w);
    return data_w + addr_w;
  endfunction

  function automatic int unsigned trc_dc_bit(int unsigned addr_w, int unsigned data_w);
    return data_w + addr_w + 1;
  endfunction

  function automatic int unsigned trc_wr_bit(int unsigned addr_w, int unsigned data_w);
    return data_w + addr_w + 2;
  endfunction

  // Bus cycle type qualifier for a comparator mode; ModeOff never qualifies.
  function automatic logic type_hit(mode_e mode, logic wr, logic dc, logic mio);
    case (mode)
      ModeFetch: return mio & ~dc & ~wr;
      ModeWrite: return mio & dc & wr;
      ModeData:  return mio & dc;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ocd_trace_fifo.sv
// First-word fall-through trace FIFO with optional overwrite-oldest on full.
module ocd_trace_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   wrap,
  input  logic [Width-1:0]       wdata,
  output logic [Width-1:0]       rdata,
  output logic                   empty,
  output logic [$clog2(Depth):0] level,
  output logic                   ovf
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr, rd_ptr;
  logic             full, pop_ok, wr_en, drop_oldest;

  assign full        = (level == (PtrW + 1)'(Depth));
  assign empty       = (level == '0);
  assign pop_ok      = pop && !empty;
  // A pop frees the head slot, so a full FIFO still accepts a simultaneous push.
  assign wr_en       = push && (!full || pop_ok || wrap);
  assign drop_oldest = push && full && !pop_ok && wrap;
  assign rdata       = mem[rd_ptr];

  // Storage write port; left unreset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok || drop_oldest) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop_ok && !drop_oldest) level <= level + 1'b1;
      else if (pop_ok && !wr_en) level <= level - 1'b1;
      if (push && full && !pop_ok && !wrap) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/ocd_watch.sv
// Bus watcher: traces every completed bus cycle and halts the CPU on a breakpoint.
module ocd_watch
  import ocd_watch_pkg::*;
#(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned NUM_BP      = 4,
  parameter int unsigned TRACE_DEPTH = 256,
  localparam int unsigned BpIdxW     = (NUM_BP > 1) ? $clog2(NUM_BP) : 1,
  localparam int unsigned LvlW       = $clog2(TRACE_DEPTH) + 1,
  localparam int unsigned TrcW       = ADDR_W + DATA_W + 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              _ads,
  input  logic              _ready,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] din,
  input  logic              wr,
  input  logic              dc,
  input  logic              mio,
  input  logic              hlda,
  input  logic              en,
  input  logic              resume,
  input  logic              cfg_we,
  input  logic [BpIdxW-1:0] cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [ADDR_W-1:0] cfg_mask,
  input  logic [1:0]        cfg_mode,
  input  logic [7:0]        cfg_count,
  input  logic              trc_wrap,
  input  logic              trc_rd,
  output logic [TrcW-1:0]   trc_data,
  output logic              trc_empty,
  output logic [LvlW-1:0]   trc_level,
  output logic              trc_ovf,
  output logic              hold,
  output logic              stopped,
  output logic [BpIdxW-1:0] brk_id
);

  localparam int unsigned ALsb  = trc_a_lsb(DATA_W);
  localparam int unsigned MioB  = trc_mio_bit(ADDR_W, DATA_W);
  localparam int unsigned DcB   = trc_dc_bit(ADDR_W, DATA_W);
  localparam int unsigned WrB   = trc_wr_bit(ADDR_W, DATA_W);

  state_e            state;
  logic [ADDR_W-1:0] a_q;
  logic [DATA_W-1:0] din_q;
  logic              wr_q, dc_q, mio_q, push_q;

  logic [ADDR_W-1:0] bp_addr [NUM_BP];
  logic [ADDR_W-1:0] bp_mask [NUM_BP];
  mode_e             bp_mode [NUM_BP];
  logic [7:0]        bp_cnt  [NUM_BP];

  logic              eval;
  logic [NUM_BP-1:0] hit, fire;
  logic [BpIdxW-1:0] fire_id;
  logic [TrcW-1:0]   trc_wdata;

  // Completion of a bus cycle that started and ended with the watch enabled.
  assign eval = (state == StData) && !_ready && en;

  // Comparator evaluation and lowest-index priority pick.
  always_comb begin
    hit     = '0;
    fire    = '0;
    fire_id = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      hit[i]  = eval && (((a_q ^ bp_addr[i]) & bp_mask[i]) == '0) &&
                type_hit(bp_mode[i], wr_q, dc_q, mio_q);
      fire[i] = hit[i] && (bp_cnt[i] == 8'd0);
    end
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (fire[i]) fire_id = BpIdxW'(i);
    end
  end

  // Pass counters and config writes; a config write lands after same-cycle evaluation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BP; i++) begin
        bp_addr[i] <= '0;
        bp_mask[i] <= '0;
        bp_mode[i] <= ModeOff;
        bp_cnt[i]  <= 8'd0;
      end
    end else begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (hit[i] && bp_cnt[i] != 8'd0) bp_cnt[i] <= bp_cnt[i] - 8'd1;
        if (cfg_we && cfg_idx == BpIdxW'(i)) begin
          bp_addr[i] <= cfg_addr;
          bp_mask[i] <= cfg_mask;
          bp_mode[i] <= mode_e'(cfg_mode);
          bp_cnt[i]  <= cfg_count;
        end
      end
    end
  end

  // Bus-cycle tracker, halt handshake and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= StIdle;
      hold    <= 1'b0;
      stopped <= 1'b0;
      brk_id  <= '0;
      a_q     <= '0;
      din_q   <= '0;
      wr_q    <= 1'b0;
      dc_q    <= 1'b0;
      mio_q   <= 1'b0;
      push_q  <= 1'b0;
    end else begin
      push_q <= eval;
      unique case (state)
        StIdle: begin
          if (en && !_ads) begin
            state <= StAddr;
            a_q   <= a;
            wr_q  <= wr;
            dc_q  <= dc;
            mio_q <= mio;
          end
        end
        StAddr: state <= StData;
        StData: begin
          if (!_ready) begin
            din_q <= din;
            if (|fire) begin
              state  <= StHalt;
              hold   <= 1'b1;
              brk_id <= fire_id;
            end else begin
              state <= StIdle;
            end
          end
        end
        StHalt: begin
          if (hlda) begin
            state   <= StStop;
            stopped <= 1'b1;
          end
        end
        StStop: begin
          if (resume) begin
            state   <= StIdle;
            hold    <= 1'b0;
            stopped <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Trace entry assembled from the registered cycle snapshot.
  always_comb begin
    trc_wdata                        = '0;
    trc_wdata[TrcDinLsb +: DATA_W]   = din_q;
    trc_wdata[ALsb +: ADDR_W]        = a_q;
    trc_wdata[MioB]                  = mio_q;
    trc_wdata[DcB]                   = dc_q;
    trc_wdata[WrB]                   = wr_q;
  end

  ocd_trace_fifo #(
    .Width(TrcW),
    .Depth(TRACE_DEPTH)
  ) u_trace (
    .clk  (clk),
    .rst  (rst),
    .push (push_q),
    .pop  (trc_rd),
    .wrap (trc_wrap),
    .wdata(trc_wdata),
    .rdata(trc_data),
    .empty(trc_empty),
    .level(trc_level),
    .ovf  (trc_ovf)
  );

endmodule
